// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the myCPU inter-stage pipeline buffers.
//  - ps_state_t   : occupancy state of a pipe_stage_buf (EMPTY / ONE / TWO)
//  - IF2ID_W      : payload width of the IF/ID boundary (PC + instruction)
//  - ID2EXE_W     : payload width of the ID/EXE boundary (PC, operands, imm, control)
//  - ps_occupancy : maps a state to the number of held entries
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,  // single-entry mode calls this FULL
    PS_TWO   = 2'd2
  } ps_state_t;

  localparam int IF2ID_W  = 64;   // pc[31:0], inst[31:0]
  localparam int ID2EXE_W = 150;  // pc, rs1/rs2 values, imm, rd, alu/mem/wb controls

  function automatic logic [1:0] ps_occupancy(input ps_state_t s);
    case (s)
      PS_ONE:  ps_occupancy = 2'd1;
      PS_TWO:  ps_occupancy = 2'd2;
      default: ps_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer (replaces the bare IF/ID and ID/EXE registers).
// Carries a DATA_W payload with a valid/allowin handshake, a per-stage stall
// (ready_go) and a flush that discards everything held.
//
// SKID=0 : one entry, in_allowin is combinational from ready_go/out_allowin.
// SKID=1 : two entries, in_allowin comes straight from a flop so the allowin
//          chain between stages is cut.
//
// Ports
//  clk          clock, rising edge
//  resetn       asynchronous reset, active-low
//  in_valid     upstream holds a valid payload
//  in_data      upstream payload
//  in_allowin   this buffer accepts a payload this cycle
//  ready_go     head payload has finished its work in this stage
//  out_valid    head payload offered downstream
//  out_data     head payload
//  out_allowin  downstream accepts this cycle
//  flush        discard all held payloads
//  occupancy    number of held entries
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                SKID      = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_allowin,
  input  logic              ready_go,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_allowin,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic valid_head;
  logic accept;
  logic pop;

  // A flush kills the upstream transfer, so nothing is accepted that cycle.
  assign accept    = in_valid && in_allowin && !flush;
  assign out_valid = valid_head && ready_go;
  assign pop       = out_valid && out_allowin;

  generate
    if (SKID == 0) begin : g_single

      ps_state_t         state_reg, state_next;
      logic [DATA_W-1:0] head_reg;

      assign valid_head = (state_reg != PS_EMPTY);
      // Room if empty, or if the head leaves on this same edge (zero bubble).
      assign in_allowin = !valid_head || (ready_go && out_allowin);
      assign out_data   = head_reg;
      assign occupancy  = ps_occupancy(state_reg);

      always_comb begin
        state_next = state_reg;
        if (flush) begin
          state_next = PS_EMPTY;
        end else if (accept) begin
          state_next = PS_ONE;
        end else if (pop) begin
          state_next = PS_EMPTY;
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          state_reg <= PS_EMPTY;
          head_reg  <= RESET_VAL;
        end else begin
          state_reg <= state_next;
          if (flush) begin
            head_reg <= RESET_VAL;
          end else if (accept) begin
            head_reg <= in_data;
          end
        end
      end

    end else begin : g_skid

      ps_state_t         state_reg, state_next;
      logic [DATA_W-1:0] head_reg, head_next;
      logic [DATA_W-1:0] skid_reg, skid_next;
      logic              allowin_reg;

      assign valid_head = (state_reg != PS_EMPTY);
      assign in_allowin = allowin_reg;
      assign out_data   = head_reg;
      assign occupancy  = ps_occupancy(state_reg);

      always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
          PS_EMPTY: begin
            if (accept) begin
              state_next = PS_ONE;
              head_next  = in_data;
            end
          end
          PS_ONE: begin
            if (accept && pop) begin
              head_next = in_data;
            end else if (accept) begin
              // Head is stuck downstream: park the newcomer behind it.
              state_next = PS_TWO;
              skid_next  = in_data;
            end else if (pop) begin
              state_next = PS_EMPTY;
            end
          end
          PS_TWO: begin
            // allowin is low here, so only a pop can happen.
            if (pop) begin
              state_next = PS_ONE;
              head_next  = skid_reg;
            end
          end
          default: state_next = PS_EMPTY;
        endcase
        if (flush) begin
          state_next = PS_EMPTY;
          head_next  = RESET_VAL;
          skid_next  = skid_reg;
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          state_reg   <= PS_EMPTY;
          head_reg    <= RESET_VAL;
          skid_reg    <= RESET_VAL;
          allowin_reg <= 1'b1;
        end else begin
          state_reg   <= state_next;
          head_reg    <= head_next;
          skid_reg    <= skid_next;
          // Registered copy of (state != TWO): no path from out_allowin.
          allowin_reg <= (state_next != PS_TWO);
        end
      end

    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf. Instance 0 is SKID=0, instance 1 is
// SKID=1; both see the same input stimulus and are checked side by side.
module tb_pipe_stage_buf;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        ready_go;
  logic        out_allowin;
  logic        flush;

  logic        allow_w [2];
  logic        ov_w    [2];
  logic [31:0] od_w    [2];
  logic [1:0]  occ_w   [2];

  int n_checks;
  int n_fail;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pipe_stage_buf #(
      .DATA_W    (32),
      .SKID      (gi),
      .RESET_VAL (32'h0)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_allowin  (allow_w[gi]),
      .ready_go    (ready_go),
      .out_valid   (ov_w[gi]),
      .out_data    (od_w[gi]),
      .out_allowin (out_allowin),
      .flush       (flush),
      .occupancy   (occ_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s skid%0d: got %h expected %h (t=%0t)", nm, m, act, exp, $time);
    end
  endtask

  // Check all four outputs of instance m.
  task automatic chk_all(input string nm, input int m, input logic e_allow, input logic e_ov,
                         input logic [31:0] e_od, input logic [1:0] e_occ);
    chk({nm, ".allowin"}, m, {31'd0, allow_w[m]}, {31'd0, e_allow});
    chk({nm, ".out_valid"}, m, {31'd0, ov_w[m]}, {31'd0, e_ov});
    chk({nm, ".out_data"}, m, od_w[m], e_od);
    chk({nm, ".occupancy"}, m, {30'd0, occ_w[m]}, {30'd0, e_occ});
  endtask

  // Apply inputs between edges; outputs settle 1 time unit later.
  task automatic drive(input logic iv, input logic [31:0] id, input logic rg,
                       input logic oa, input logic fl);
    @(negedge clk);
    in_valid    = iv;
    in_data     = id;
    ready_go    = rg;
    out_allowin = oa;
    flush       = fl;
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        oa;
    logic [1:0]  allow;  // bit m = expected in_allowin of instance m
    logic [1:0]  ov;
    logic [31:0] od;
    logic [1:0]  occ0;
    logic [1:0]  occ1;
  } vec_t;

  vec_t vec [8];

  // Reference model: a FIFO of capacity 1+SKID per instance.
  int          cnt    [2];
  logic [31:0] fq     [2][2];
  logic [31:0] shadow [2];
  logic        e_allow, e_ov, acc, pp;
  logic [31:0] e_od;
  logic        r_iv, r_rg, r_oa, r_fl;
  logic [31:0] r_id;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    ready_go    = 1'b1;
    out_allowin = 1'b1;
    flush       = 1'b0;

    // Streaming with backpressure: iv, id, oa, allow, ov, od, occ(skid0), occ(skid1)
    vec[0] = '{1'b1, 32'd1, 1'b1, 2'b11, 2'b00, 32'd0, 2'd0, 2'd0};
    vec[1] = '{1'b1, 32'd2, 1'b1, 2'b11, 2'b11, 32'd1, 2'd1, 2'd1};
    vec[2] = '{1'b1, 32'd3, 1'b0, 2'b10, 2'b11, 32'd2, 2'd1, 2'd1};
    vec[3] = '{1'b1, 32'd3, 1'b0, 2'b00, 2'b11, 32'd2, 2'd1, 2'd2};
    vec[4] = '{1'b1, 32'd3, 1'b1, 2'b01, 2'b11, 32'd2, 2'd1, 2'd2};
    vec[5] = '{1'b1, 32'd4, 1'b1, 2'b11, 2'b11, 32'd3, 2'd1, 2'd1};
    vec[6] = '{1'b0, 32'd5, 1'b1, 2'b11, 2'b11, 32'd4, 2'd1, 2'd1};
    vec[7] = '{1'b0, 32'd6, 1'b1, 2'b11, 2'b00, 32'd4, 2'd0, 2'd0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) chk_all("reset", m, 1'b1, 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven streaming / backpressure
    for (int i = 0; i < 8; i++) begin
      drive(vec[i].iv, vec[i].id, 1'b1, vec[i].oa, 1'b0);
      for (int m = 0; m < 2; m++)
        chk_all($sformatf("vec%0d", i), m, vec[i].allow[m], vec[i].ov[m], vec[i].od,
                (m == 0) ? vec[i].occ0 : vec[i].occ1);
      $display("vec %0d: in_valid=%0d in_data=%0d out_allowin=%0d -> od0=%0d od1=%0d occ0=%0d occ1=%0d",
               i, vec[i].iv, vec[i].id, vec[i].oa, od_w[0], od_w[1], occ_w[0], occ_w[1]);
    end

    // Stall: head held while ready_go=0, emitted exactly once afterwards
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0);
      for (int m = 0; m < 2; m++) begin
        chk("stall.out_valid", m, {31'd0, ov_w[m]}, 32'd0);
        chk("stall.out_data", m, od_w[m], 32'hDEADBEEF);
        chk("stall.occupancy", m, {30'd0, occ_w[m]}, 32'd1);
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) chk_all("stall_release", m, 1'b1, 1'b1, 32'hDEADBEEF, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) chk("stall_once.out_valid", m, {31'd0, ov_w[m]}, 32'd0);
    $display("stall sequence done");

    // Accept and pop on the same edge
    drive(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) chk_all("accpop_before", m, 1'b1, 1'b1, 32'hA, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) chk("accpop_after.out_data", m, od_w[m], 32'hB);
    for (int m = 0; m < 2; m++) chk("accpop_after.occupancy", m, {30'd0, occ_w[m]}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) chk("accpop_drain.occupancy", m, {30'd0, occ_w[m]}, 32'd0);
    $display("accept+pop sequence done");

    // Flush with a payload arriving and SKID=1 holding two entries
    drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b1, 1'b1, 1'b1);
    chk_all("flush_before", 1, 1'b0, 1'b1, 32'h11, 2'd2);
    chk_all("flush_before", 0, 1'b1, 1'b1, 32'h11, 2'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      for (int m = 0; m < 2; m++) chk_all("flush_after", m, 1'b1, 1'b0, 32'h0, 2'd0);
    end
    $display("flush sequence done");

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h101, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h102, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h103, 1'b1, 1'b0, 1'b0);
    chk("pre_reset.occupancy", 1, {30'd0, occ_w[1]}, 32'd2);
    chk("pre_reset.occupancy", 0, {30'd0, occ_w[0]}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) chk_all("async_reset", m, 1'b1, 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) chk_all("post_reset", m, 1'b1, 1'b0, 32'h0, 2'd0);
    $display("async reset sequence done");

    // Randomised run against the FIFO reference model
    for (int m = 0; m < 2; m++) begin
      cnt[m]    = 0;
      shadow[m] = 32'h0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      r_iv = ($urandom_range(3) != 0);
      r_id = $urandom;
      r_rg = ($urandom_range(3) != 0);
      r_oa = ($urandom_range(2) != 0);
      r_fl = ($urandom_range(31) == 0);
      drive(r_iv, r_id, r_rg, r_oa, r_fl);
      for (int m = 0; m < 2; m++) begin
        e_allow = (m == 0) ? ((cnt[m] == 0) || (r_rg && r_oa)) : (cnt[m] < 2);
        e_ov    = (cnt[m] > 0) && r_rg;
        e_od    = (cnt[m] > 0) ? fq[m][0] : shadow[m];
        chk_all("rand", m, e_allow, e_ov, e_od, cnt[m][1:0]);
        chk("inv_capacity", m, {31'd0, (occ_w[m] > 2'(1 + m))}, 32'd0);
        chk("inv_valid_occ", m, {31'd0, (ov_w[m] && occ_w[m] == 2'd0)}, 32'd0);
        if (r_fl) begin
          cnt[m]    = 0;
          shadow[m] = 32'h0;
        end else begin
          acc = r_iv && e_allow;
          pp  = e_ov && r_oa;
          if (pp) begin
            fq[m][0] = fq[m][1];
            cnt[m]--;
          end
          if (acc) begin
            fq[m][cnt[m]] = r_id;
            cnt[m]++;
          end
          if (cnt[m] > 0) shadow[m] = fq[m][0];
        end
      end
    end
    $display("random phase done: 2000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
